// File: rtl/dmem_dump_streamer_if.sv
// Bundles the memory read port 1 and the byte output stream of the dump streamer.
// Byte stream: a byte moves on any rising edge where out_valid && out_ready; once
// out_valid rises, out_valid and out_data hold until that edge, and out_ready is ignored while out_valid=0.
interface dmem_dump_streamer_if;
    logic [31:0] rd_addr;
    logic [31:0] rd_data;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;

    modport master (
        output rd_addr,
        input  rd_data,
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  rd_addr,
        output rd_data,
        input  out_data,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/dmem_dump_streamer.sv
// Walks NUM_WORDS words starting at BASE_ADDR on the memory's read-only port and
// streams each word as four bytes, least-significant byte first.
module dmem_dump_streamer #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned NUM_WORDS = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic [1:0] dbg_state,
    dmem_dump_streamer_if.master bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [9:0] LAST_IDX = 10'(NUM_WORDS - 1);

    state_t      state_q, state_d;
    logic [9:0]  idx_q, idx_d;
    logic [1:0]  k_q, k_d;
    logic [31:0] word_q, word_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            k_q     <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            k_q     <= k_d;
            word_q  <= word_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        k_d           = k_q;
        word_d        = word_q;
        bus.out_valid = 1'b0;
        busy          = 1'b1;
        done          = 1'b0;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    idx_d   = '0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                // The read port is combinational: the word for idx_q is on rd_data now.
                word_d  = bus.rd_data;
                k_d     = 2'd0;
                state_d = SEND;
            end
            SEND: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    if (k_q != 2'd3) begin
                        k_d = k_q + 2'd1;
                    end else if (idx_q != LAST_IDX) begin
                        idx_d   = idx_q + 10'd1;
                        state_d = FETCH;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Address comes straight from the idx register, so it never glitches between states.
    assign bus.rd_addr  = BASE_ADDR + {20'd0, idx_q, 2'b00};
    assign bus.out_data = (state_q == SEND) ? word_q[{k_q, 3'b000} +: 8] : 8'h00;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_dmem_dump_streamer.sv
// Bench for dmem_dump_streamer: directed scenarios with literal expectations plus
// randomized runs checked every cycle against a byte-queue model of the dump.
module tb_dmem_dump_streamer;

    localparam logic [31:0] BASE = 32'h0000_0100;
    localparam int          NW   = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       busy;
    logic       done;
    logic [1:0] dbg_state;

    dmem_dump_streamer_if bus ();

    dmem_dump_streamer #(
        .BASE_ADDR (BASE),
        .NUM_WORDS (NW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .dbg_state (dbg_state),
        .bus       (bus.master)
    );

    // clock / reset
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // memory port 1: 16 words from BASE, combinational read
    logic [31:0] mem [16];
    assign bus.rd_data = mem[bus.rd_addr[5:2]];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // scoreboard / behavioural model
    logic [7:0] exp_q[$];
    logic [7:0] rec_q[$];
    bit         chk_en  = 0;
    bit         m_busy  = 0;
    bit         m_fetch = 0;
    bit         m_done  = 0;
    int         m_word  = 0;
    int         done_cnt = 0;
    int         exp_runs = 0;
    int         t0 = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            logic exp_valid;
            exp_valid = m_busy && !m_fetch && !m_done;
            chk("busy", {31'd0, busy}, {31'd0, m_busy});
            chk("done", {31'd0, done}, {31'd0, m_done});
            chk("out_valid", {31'd0, bus.out_valid}, {31'd0, exp_valid});
            chk("rd_addr", bus.rd_addr, BASE + 32'(m_word) * 32'd4);
            if (exp_valid)
                chk("out_data", {24'd0, bus.out_data}, {24'd0, exp_q[0]});
            if (done)
                done_cnt++;
            if (rst_n && bus.out_valid && bus.out_ready)
                rec_q.push_back(bus.out_data);

            // advance the model across the coming rising edge
            if (!rst_n) begin
                m_busy = 0; m_fetch = 0; m_done = 0; m_word = 0;
                exp_q.delete();
            end else if (m_done) begin
                m_done = 0;
                m_busy = 0;
            end else if (!m_busy) begin
                if (start) begin
                    m_busy = 1; m_fetch = 1; m_word = 0;
                end
            end else if (m_fetch) begin
                for (int b = 0; b < 4; b++)
                    exp_q.push_back(mem[m_word][8*b +: 8]);
                m_fetch = 0;
            end else if (bus.out_ready) begin
                void'(exp_q.pop_front());
                if (exp_q.size() == 0) begin
                    if (m_word == NW - 1) m_done = 1;
                    else begin
                        m_word++;
                        m_fetch = 1;
                    end
                end
            end
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        t0 = cyc;
        exp_runs++;
        step();
        start = 1'b0;
    endtask

    task automatic set_basic_mem();
        mem[0] = 32'h4433_2211;
        mem[1] = 32'hDDCC_BBAA;
        mem[2] = 32'h7766_5544;
        mem[3] = 32'h0123_4567;
    endtask

    // mode 0: ready high; 1: backpressure on byte 2 of word 0; 2: snapshot writes;
    // 3: start pulses in SEND and DONE; 4: random ready, writes and starts
    task automatic run_dump(input int mode, input int budget, output int done_rel);
        bit got;
        int rel;
        got = 0;
        done_rel = -1;
        for (int i = 0; i < budget && !got; i++) begin
            rel = cyc - t0;
            start = 1'b0;
            bus.out_ready = 1'b1;
            case (mode)
                1: if (rel >= 4 && rel <= 6) bus.out_ready = 1'b0;
                2: if (rel == 3) begin
                    mem[0] = 32'hFFFF_FFFF;
                    mem[1] = 32'hFFFF_FFFF;
                end
                3: if (rel == 3 || rel == 21) start = 1'b1;
                4: begin
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                    if ($urandom_range(0, 3) == 0) mem[$urandom_range(0, 15)] = $urandom;
                    if ($urandom_range(0, 7) == 0) start = 1'b1;
                end
                default: ;
            endcase
            @(negedge clk);
            if (mode == 1 && rel >= 4 && rel <= 7) begin
                chk("bp_hold_valid", {31'd0, bus.out_valid}, 32'd1);
                chk("bp_hold_data", {24'd0, bus.out_data}, 32'h33);
            end
            if (done) begin
                got = 1;
                done_rel = rel;
            end
            step();
        end
        start = 1'b0;
        bus.out_ready = 1'b1;
        if (!got) chk("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] basic_bytes [8];
        int dr;
        basic_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        rst_n = 1'b0;
        start = 1'b1;                      // reset must win over start
        bus.out_ready = 1'b0;
        step();
        step();
        start = 1'b0;
        chk_en = 1;
        @(negedge clk);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_out_data", {24'd0, bus.out_data}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_rd_addr", bus.rd_addr, 32'h100);
        step();
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        step();

        // basic dump with literal timing
        set_basic_mem();
        pulse_start();
        for (int r = 1; r <= 22; r++) begin
            @(negedge clk);
            if (r >= 2 && r <= 5) chk("basic_byte", {24'd0, bus.out_data}, {24'd0, basic_bytes[r-2]});
            if (r >= 7 && r <= 10) chk("basic_byte", {24'd0, bus.out_data}, {24'd0, basic_bytes[r-3]});
            if (r == 1)  chk("fetch_addr0", bus.rd_addr, 32'h100);
            if (r == 6)  chk("fetch_addr1", bus.rd_addr, 32'h104);
            if (r == 11) chk("fetch_addr2", bus.rd_addr, 32'h108);
            if (r == 21) chk("basic_done", {31'd0, done}, 32'd1);
            if (r == 22) chk("basic_busy_low", {31'd0, busy}, 32'd0);
            step();
        end
        chk("idle_addr_last", bus.rd_addr, 32'h10C);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_addr_after_rst", bus.rd_addr, 32'h100);
        step();

        // backpressure: done slips by exactly 3 cycles
        set_basic_mem();
        pulse_start();
        run_dump(1, 100, dr);
        chk("bp_done_cycle", 32'(dr), 32'd24);

        // snapshot
        set_basic_mem();
        rec_q.delete();
        pulse_start();
        run_dump(2, 100, dr);
        chk("snap_count", 32'(rec_q.size()), 32'd16);
        for (int b = 0; b < 4; b++) begin
            chk("snap_word0", {24'd0, rec_q[b]}, {24'd0, basic_bytes[b]});
            chk("snap_word1", {24'd0, rec_q[4+b]}, 32'hFF);
        end

        // start while busy
        set_basic_mem();
        pulse_start();
        run_dump(3, 100, dr);
        chk("busy_start_done_cycle", 32'(dr), 32'd21);
        repeat (4) step();
        chk("busy_start_one_done", 32'(done_cnt), 32'(exp_runs));

        // reset mid-run during byte 1 of word 0
        set_basic_mem();
        pulse_start();
        exp_runs--;                        // this run is aborted, no done
        step();
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_addr", bus.rd_addr, 32'h100);
        repeat (3) step();
        chk("abort_no_done", 32'(done_cnt), 32'(exp_runs));
        rec_q.delete();
        pulse_start();
        run_dump(0, 100, dr);
        chk("restart_done_cycle", 32'(dr), 32'd21);
        chk("restart_first_byte", {24'd0, rec_q[0]}, 32'h11);
        chk("restart_count", 32'(rec_q.size()), 32'd16);

        // randomized runs
        for (int run = 0; run < 8; run++) begin
            for (int i = 0; i < 16; i++) mem[i] = $urandom;
            repeat ($urandom_range(1, 3)) step();
            pulse_start();
            run_dump(4, 400, dr);
        end
        repeat (3) step();
        chk("total_done_pulses", 32'(done_cnt), 32'(exp_runs));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_dump_streamer.md
# dmem_dump_streamer

Read-only consumer of the data memory's second (read-only) port. On a start pulse it walks a contiguous window of words, captures each word, and streams it out as four bytes, least-significant byte first, over a valid/ready byte interface. This interface is intended to drive a UART transmitter or debug link, so memory contents can be dumped while the CPU keeps using port 0.

## Interface
- `BASE_ADDR`, default 32'h0000_0000: byte address of the first word. Bits [1:0] must be 0.
- `NUM_WORDS`, default 1024: number of words dumped per run. Legal range is 1..1024.
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: reset, synchronous and active-low.
- `start`, input, 1: begin a dump; sampled only in IDLE.
- `rd_addr`, output, 32: byte address driven to the memory read port 1 address.
- `rd_data`, input, 32: combinational read data from memory port 1.
- `out_data`, output, 8: byte being offered.
- `out_valid`, output, 1: `out_data` is valid.
- `out_ready`, input, 1: sink accepts the byte.
- `busy`, output, 1: high whenever the block is not in IDLE.
- `done`, output, 1: one-cycle pulse when the last byte of the run has been accepted.

## Operation
- The FSM has four states: IDLE, FETCH, SEND and DONE.
- **IDLE**
  - `out_valid`=0, `busy`=0, `done`=0.
  - On `start`=1, word index `idx` is set to 0 and the FSM goes to FETCH. Otherwise it stays in IDLE.
- **FETCH** (always one cycle)
  - `rd_data` is captured into the 32-bit holding register `word_q`.
  - Byte counter `k` is set to 0 and the FSM goes to SEND.
- **SEND**
  - `out_valid`=1 and `out_data` = `word_q[8k+7:8k]`.
  - On `out_valid && out_ready`:
    - If k<3: k increments and the FSM stays in SEND.
    - If k=3 and idx<NUM_WORDS-1: idx increments and the FSM goes to FETCH.
    - If k=3 and idx=NUM_WORDS-1: the FSM goes to DONE.
- **DONE** (always one cycle): `done`=1, `busy`=1, `out_valid`=0; the FSM then returns to IDLE.
- `rd_addr` = BASE_ADDR + {idx, 2'b00}, computed modulo 2^32. It is registered-derived, so it is glitch-free and stable in every state.
- `start` is ignored in FETCH, SEND and DONE. There is no queued restart.
- **Snapshot semantics:** each word is sampled exactly once, in its FETCH cycle.
  - A port-0 write to that word after its FETCH is not reflected in the stream.
  - A write to a later word, made before that word's FETCH, is reflected.
- The block never drives memory write signals.

## Timing
- **Reset:** while `rst_n`=0 at a rising edge, the following are cleared:
  - state = IDLE, `idx`=0, `k`=0, `word_q`=0.
  - Resulting outputs: `out_valid`=0, `out_data`=0, `busy`=0, `done`=0, `rd_addr`=BASE_ADDR.
  - Reset mid-run aborts immediately. No partial `done` is produced, and any byte in flight is dropped.
- **Cycle timing, with start accepted at cycle 0:**
  - FETCH in cycle 1; SEND for byte 0 from cycle 2.
- **With `out_ready` held high:** 5 cycles per word.
  - Byte j of word w is valid in cycle 2 + 5w + j.
  - `done` is asserted in cycle 5·NUM_WORDS + 1; IDLE resumes in cycle 5·NUM_WORDS + 2.
- **Handshake:**
  - While `out_valid`=1 and `out_ready`=0, `out_data` holds stable and `out_valid` stays high. There is no timeout.
  - `out_valid` never drops before its byte is accepted.
  - `out_ready` is ignored when `out_valid`=0.
- `rd_data` is consumed in the same cycle `rd_addr` is presented. This relies on the memory's combinational read, so no extra wait state is required.
- **Widths:** `idx` is 10 bits and `k` is 2 bits.
  - With NUM_WORDS=1024, the final `idx`=1023 does not wrap before DONE.
  - Address wrap past 2^32 is modular and not flagged.
- **Simultaneous `start` and `rst_n`=0:** reset wins.

## Test plan
- **Basic dump.**
  - Setup: NUM_WORDS=2, BASE_ADDR=0, memory[0]=32'h4433_2211, memory[1]=32'hDDCC_BBAA, `out_ready`=1, pulse `start`.
  - Required bytes: 11, 22, 33, 44, AA, BB, CC, DD in cycles 2–5 and 7–10.
  - Required `done` in cycle 11; `busy` low in cycle 12.
- **Backpressure.**
  - Stimulus: hold `out_ready`=0 for 3 cycles on byte 2 of word 0.
  - Required: `out_data`=33 and `out_valid`=1 held throughout, with no duplicate or lost bytes. `done` is delayed by exactly 3 cycles.
- **Address generation.**
  - Setup: BASE_ADDR=32'h0000_0100, NUM_WORDS=3.
  - Required: `rd_addr` reads 100, 104 and 108 in the respective FETCH cycles.
  - Required: after DONE, an idle `rd_addr` of 100 following a new reset.
- **Snapshot.**
  - Stimulus: a port-0 write of 32'hFFFF_FFFF to word 0 during its SEND, and to word 1 before its FETCH.
  - Required: word 0 streams its old value; word 1 streams FF FF FF FF.
- **Reset mid-run.**
  - Stimulus: assert `rst_n`=0 during SEND byte 1, then release.
  - Required: the next cycle shows `out_valid`=0, `busy`=0, `done` never asserted, and `rd_addr`=BASE_ADDR.
  - Required: a new `start` restarts from word 0.
- **Start while busy.**
  - Stimulus: pulse `start` during SEND and during DONE.
  - Required: no effect, and exactly one `done` pulse per accepted start.
